// File: rtl/rv_mau_pkg.sv
// rv_mau_pkg: shared types and helpers for the memory-access-stage controller.
// Holds the FSM state enum, RV32I funct3 size/sign encodings and the store
// lane helpers (byte enables and lane replication of store data).
package rv_mau_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    WB   = 2'b10
  } mau_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte enables for an access; halfwords and words drop the low address
  // bits so a misaligned access lands on the aligned-down lanes.
  function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3)
      F3_B, F3_BU: store_be = 4'b0001 << lane;
      F3_H, F3_HU: store_be = 4'b0011 << {lane[1], 1'b0};
      default:     store_be = 4'b1111;
    endcase
  endfunction

  // Replicate the low byte/halfword onto every lane so the byte enables alone
  // select which memory bytes change.
  function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] data);
    case (funct3)
      F3_B, F3_BU: store_data = {4{data[7:0]}};
      F3_H, F3_HU: store_data = {2{data[15:0]}};
      default:     store_data = data;
    endcase
  endfunction

endpackage

// File: rtl/mau_load_align.sv
// mau_load_align: combinational load-data aligner.
// Shifts the raw memory word down to the addressed lane and sign/zero extends
// according to funct3. Halfword and word loads ignore the low address bits
// that would make them misaligned.
// Ports:
//   rdata   in  XLEN  raw word from memory
//   lane    in  2     byte offset of the access (addr[1:0])
//   funct3  in  3     RV32I load size/sign
//   wb_data out XLEN  aligned, extended load result
module mau_load_align
  import rv_mau_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      lane,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] wb_data
);

  logic [1:0]      lane_eff_s;
  logic [XLEN-1:0] shifted_s;

  // Effective lane (aligned down per access size), shift and extend.
  always_comb begin
    lane_eff_s = 2'b00;
    wb_data    = {XLEN{1'b0}};
    case (funct3)
      F3_B, F3_BU: lane_eff_s = lane;
      F3_H, F3_HU: lane_eff_s = {lane[1], 1'b0};
      default:     lane_eff_s = 2'b00;
    endcase
    shifted_s = rdata >> {lane_eff_s, 3'b000};
    case (funct3)
      F3_B:    wb_data = {{(XLEN-8){shifted_s[7]}}, shifted_s[7:0]};
      F3_BU:   wb_data = {{(XLEN-8){1'b0}}, shifted_s[7:0]};
      F3_H:    wb_data = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
      F3_HU:   wb_data = {{(XLEN-16){1'b0}}, shifted_s[15:0]};
      default: wb_data = shifted_s;
    endcase
  end

endmodule

// File: rtl/mau_conflict_ctrl.sv
// mau_conflict_ctrl: memory-access-stage controller.
// Accepts one load/store from EX while idle, drives a held req/ack handshake to
// a multi-cycle data memory, returns aligned load data to writeback as a
// one-cycle pulse, and raises MAU_data_conflict to stall fetch/decode/regfile
// while memory is busy or while a just-completed load feeds decode.
// Optional feature: define MAU_TIMEOUT_EN to abort a request after TIMEOUT
// cycles without mem_ack and set the sticky mau_timeout_err.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   ex_mem_valid/ex_is_store/ex_funct3/ex_rd/ex_addr/ex_wdata   op from EX
//   dec_rs1/dec_rs2/dec_rs1_used/dec_rs2_used                    decode sources
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata                     memory request
//   mem_ack/mem_rdata                                            memory response
//   wb_valid/wb_rd/wb_data                                       load writeback
//   MAU_data_conflict                                            stall request
//   mau_timeout_err                                              sticky timeout
module mau_conflict_ctrl
  import rv_mau_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_mem_valid,
  input  logic            ex_is_store,
  input  logic [2:0]      ex_funct3,
  input  logic [4:0]      ex_rd,
  input  logic [AW-1:0]   ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic            dec_rs1_used,
  input  logic            dec_rs2_used,
  output logic            mem_req,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            MAU_data_conflict,
  output logic            mau_timeout_err
);

  mau_state_e      state_r;
  logic            is_store_r;
  logic [2:0]      funct3_r;
  logic [1:0]      lane_r;
  logic [4:0]      rd_r;
  logic [XLEN-1:0] align_data_s;
  logic            conflict_s;

`ifdef MAU_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_cnt_r;
`else
  logic [31:0] unused_timeout_s;
  assign unused_timeout_s = 32'(TIMEOUT);
  assign mau_timeout_err  = 1'b0;
`endif

  mau_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (mem_rdata),
    .lane   (lane_r),
    .funct3 (funct3_r),
    .wb_data(align_data_s)
  );

  // Request/writeback FSM with all memory and writeback outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'b0000;
      mem_addr   <= {AW{1'b0}};
      mem_wdata  <= {XLEN{1'b0}};
      wb_valid   <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= {XLEN{1'b0}};
      is_store_r <= 1'b0;
      funct3_r   <= 3'b000;
      lane_r     <= 2'b00;
      rd_r       <= 5'd0;
`ifdef MAU_TIMEOUT_EN
      tmo_cnt_r       <= {TW{1'b0}};
      mau_timeout_err <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          wb_valid <= 1'b0;
          if (ex_mem_valid) begin
            state_r    <= BUSY;
            mem_req    <= 1'b1;
            mem_we     <= ex_is_store;
            mem_be     <= store_be(ex_funct3, ex_addr[1:0]);
            mem_addr   <= {ex_addr[AW-1:2], 2'b00};
            mem_wdata  <= store_data(ex_funct3, ex_wdata);
            is_store_r <= ex_is_store;
            funct3_r   <= ex_funct3;
            lane_r     <= ex_addr[1:0];
            rd_r       <= ex_rd;
`ifdef MAU_TIMEOUT_EN
            tmo_cnt_r  <= {TW{1'b0}};
`endif
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (is_store_r) begin
              state_r <= IDLE;
            end else begin
              // Capture the aligned word at ack; memory need not hold rdata.
              state_r  <= WB;
              wb_valid <= 1'b1;
              wb_rd    <= rd_r;
              wb_data  <= align_data_s;
            end
          end
`ifdef MAU_TIMEOUT_EN
          else if (tmo_cnt_r == TMO_LAST) begin
            // Abandon the access; a load result is discarded.
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mau_timeout_err <= 1'b1;
            state_r         <= IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
`endif
        end
        WB: begin
          wb_valid <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          state_r  <= IDLE;
          mem_req  <= 1'b0;
          mem_we   <= 1'b0;
          wb_valid <= 1'b0;
        end
      endcase
    end
  end

  // Stall while an op is being accepted or in flight, and during writeback
  // when decode reads the register the load is about to write.
  always_comb begin
    conflict_s = 1'b0;
    case (state_r)
      IDLE:    conflict_s = ex_mem_valid;
      BUSY:    conflict_s = 1'b1;
      WB:      conflict_s = (rd_r != 5'd0) &&
                            ((dec_rs1_used && (dec_rs1 == rd_r)) ||
                             (dec_rs2_used && (dec_rs2 == rd_r)));
      default: conflict_s = 1'b0;
    endcase
  end

  assign MAU_data_conflict = conflict_s;

endmodule
